// File: rtl/conv_window_controller.sv
// Sliding-window controller: walks a padded frame beat by beat and emits window descriptors.
// Define CWC_VPAD_EN to generate top/bottom pad rows; by default only columns are padded.
module conv_window_controller #(
    parameter int unsigned KER_SIZE    = 3,
    parameter int unsigned INPUT_X_DIM = 8,
    parameter int unsigned INPUT_Y_DIM = 8,
    parameter int unsigned PAD         = 1,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned CHANNELS    = 1,
    localparam int unsigned PX         = INPUT_X_DIM + 2 * PAD,
`ifdef CWC_VPAD_EN
    localparam int unsigned PY         = INPUT_Y_DIM + 2 * PAD,
`else
    localparam int unsigned PY         = INPUT_Y_DIM,
`endif
    localparam int unsigned OX         = (PX - KER_SIZE) / STRIDE + 1,
    localparam int unsigned OY         = (PY - KER_SIZE) / STRIDE + 1,
    localparam int unsigned CW         = $clog2(CHANNELS + 1),
    localparam int unsigned KW         = $clog2(KER_SIZE + 1),
    localparam int unsigned OXW        = $clog2(OX + 1),
    localparam int unsigned OYW        = $clog2(OY + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                win_ready,
    output logic                win_valid,
    output logic [CW-1:0]       ch_idx,
    output logic [KW-1:0]       col_ptr,
    output logic [OXW-1:0]      out_x,
    output logic [OYW-1:0]      out_y,
    output logic [KER_SIZE-1:0] left_pad_mask,
    output logic [KER_SIZE-1:0] right_pad_mask,
    output logic [KER_SIZE-1:0] top_pad_mask,
    output logic [KER_SIZE-1:0] bot_pad_mask,
    output logic                frame_done
);

    // Position counters carry STRIDE of headroom for the next-window trackers.
    localparam int unsigned GW = $clog2(PX + STRIDE);
    localparam int unsigned RW = $clog2(PY + STRIDE);

    typedef enum logic [1:0] {PAD_COL, DATA_COL, WIN_HOLD} state_t;
    localparam state_t RESET_STATE = (PAD > 0) ? PAD_COL : DATA_COL;

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [GW-1:0]       g_q, g_d, xn_q, xn_d;
    logic [RW-1:0]       r_q, r_d, yn_q, yn_d;
    logic [KW-1:0]       kcol_q, kcol_d;
    logic [OXW-1:0]      ox_q, ox_d, out_x_q, out_x_d;
    logic [OYW-1:0]      oy_q, oy_d, out_y_q, out_y_d;
    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [KER_SIZE-1:0] left_c, right_c, left_q, left_d, right_q, right_d;
    logic                stall, beat, ch_last, g_last, r_last, qualify, pad_d;

    function automatic logic col_is_pad(input logic [GW-1:0] g);
        return (32'(g) < PAD) || (32'(g) >= PAD + INPUT_X_DIM);
    endfunction

    // Window column g-K+1+i is pad; offset by K to stay unsigned.
    for (genvar i = 0; i < KER_SIZE; i++) begin : g_hmask
        assign left_c[i]  = (32'(g_q) + 32'(i) + 32'd1) < (PAD + KER_SIZE);
        assign right_c[i] = (32'(g_q) + 32'(i) + 32'd1) >= (PAD + INPUT_X_DIM + KER_SIZE);
    end

`ifdef CWC_VPAD_EN
    logic [KER_SIZE-1:0] top_c, bot_c, top_q, top_d, bot_q, bot_d;

    function automatic logic row_is_pad(input logic [RW-1:0] r);
        return (32'(r) < PAD) || (32'(r) >= PAD + INPUT_Y_DIM);
    endfunction

    for (genvar i = 0; i < KER_SIZE; i++) begin : g_vmask
        assign top_c[i] = (32'(r_q) + 32'(i) + 32'd1) < (PAD + KER_SIZE);
        assign bot_c[i] = (32'(r_q) + 32'(i) + 32'd1) >= (PAD + INPUT_Y_DIM + KER_SIZE);
    end

    always_comb begin
        top_d = top_q;
        bot_d = bot_q;
        if (qualify) begin
            top_d = top_c;
            bot_d = bot_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            bot_q <= '0;
        end else begin
            top_q <= top_d;
            bot_q <= bot_d;
        end
    end

    assign top_pad_mask = top_q;
    assign bot_pad_mask = bot_q;
`else
    assign top_pad_mask = '0;
    assign bot_pad_mask = '0;
`endif

    // Next-state, stream counters and window descriptor.
    always_comb begin
        stall    = win_valid_q && !win_ready;
        beat     = !stall && ((state_q == PAD_COL) || ((state_q == DATA_COL) && in_valid));
        ch_last  = (ch_q == CW'(CHANNELS - 1));
        g_last   = (g_q == GW'(PX - 1));
        r_last   = (r_q == RW'(PY - 1));
        qualify  = beat && ch_last && (g_q == xn_q) && (r_q == yn_q);
        in_ready = (state_q == DATA_COL) && !stall;

        ch_d         = ch_q;
        g_d          = g_q;
        r_d          = r_q;
        kcol_d       = kcol_q;
        xn_d         = xn_q;
        ox_d         = ox_q;
        yn_d         = yn_q;
        oy_d         = oy_q;
        win_valid_d  = win_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        left_d       = left_q;
        right_d      = right_q;
        frame_done_d = beat && ch_last && g_last && r_last;

        if (beat) begin
            ch_d = ch_q + CW'(1);
            if (ch_last) begin
                ch_d   = '0;
                g_d    = g_q + GW'(1);
                kcol_d = (kcol_q == KW'(KER_SIZE - 1)) ? '0 : kcol_q + KW'(1);
                if (g_q == xn_q) begin
                    xn_d = xn_q + GW'(STRIDE);
                    ox_d = ox_q + OXW'(1);
                end
                if (g_last) begin
                    g_d    = '0;
                    kcol_d = '0;
                    xn_d   = GW'(KER_SIZE - 1);
                    ox_d   = '0;
                    r_d    = r_q + RW'(1);
                    if (r_q == yn_q) begin
                        yn_d = yn_q + RW'(STRIDE);
                        oy_d = oy_q + OYW'(1);
                    end
                    if (r_last) begin
                        r_d  = '0;
                        yn_d = RW'(KER_SIZE - 1);
                        oy_d = '0;
                    end
                end
            end
        end

        if (qualify) begin
            win_valid_d = 1'b1;
            out_x_d     = ox_q;
            out_y_d     = oy_q;
            left_d      = left_c;
            right_d     = right_c;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

`ifdef CWC_VPAD_EN
        pad_d = col_is_pad(g_d) || row_is_pad(r_d);
`else
        pad_d = col_is_pad(g_d);
`endif
        if (stall) begin
            state_d = WIN_HOLD;
        end else if (pad_d) begin
            state_d = PAD_COL;
        end else begin
            state_d = DATA_COL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            ch_q         <= '0;
            g_q          <= '0;
            r_q          <= '0;
            kcol_q       <= '0;
            xn_q         <= GW'(KER_SIZE - 1);
            ox_q         <= '0;
            yn_q         <= RW'(KER_SIZE - 1);
            oy_q         <= '0;
            win_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            left_q       <= '0;
            right_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            g_q          <= g_d;
            r_q          <= r_d;
            kcol_q       <= kcol_d;
            xn_q         <= xn_d;
            ox_q         <= ox_d;
            yn_q         <= yn_d;
            oy_q         <= oy_d;
            win_valid_q  <= win_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            left_q       <= left_d;
            right_q      <= right_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid      = win_valid_q;
    assign ch_idx         = ch_q;
    assign col_ptr        = kcol_q;
    assign out_x          = out_x_q;
    assign out_y          = out_y_q;
    assign left_pad_mask  = left_q;
    assign right_pad_mask = right_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_conv_window_controller.sv
// Bench for conv_window_controller: two configurations scored against a frame-level window model.
module tb_conv_window_controller;

    localparam int K0 = 3, X0 = 4, Y0 = 4, P0 = 1, S0 = 1, C0 = 1;
    localparam int K1 = 3, X1 = 5, Y1 = 5, P1 = 1, S1 = 2, C1 = 3;
`ifdef CWC_VPAD_EN
    localparam int VP = 1;
`else
    localparam int VP = 0;
`endif
    localparam int PX0 = X0 + 2 * P0, PY0 = Y0 + 2 * P0 * VP;
    localparam int PX1 = X1 + 2 * P1, PY1 = Y1 + 2 * P1 * VP;
    localparam int OX0 = (PX0 - K0) / S0 + 1, OY0 = (PY0 - K0) / S0 + 1;
    localparam int OX1 = (PX1 - K1) / S1 + 1, OY1 = (PY1 - K1) / S1 + 1;

    localparam int CK [2] = '{K0, K1};
    localparam int CX [2] = '{X0, X1};
    localparam int CY [2] = '{Y0, Y1};
    localparam int CP [2] = '{P0, P1};
    localparam int CS [2] = '{S0, S1};
    localparam int CC [2] = '{C0, C1};

    logic clk;
    logic rst;
    logic iv_a [2];
    logic wr_a [2];
    logic ir_a [2];
    logic wv_a [2];
    logic fd_a [2];
    logic [7:0] chi_a [2], cp_a [2], ox_a [2], oy_a [2];
    logic [7:0] lm_a [2], rm_a [2], tm_a [2], bm_a [2];

    logic [$clog2(C0+1)-1:0]  chi0;
    logic [$clog2(K0+1)-1:0]  cp0;
    logic [$clog2(OX0+1)-1:0] ox0;
    logic [$clog2(OY0+1)-1:0] oy0;
    logic [K0-1:0]            lm0, rm0, tm0, bm0;
    logic [$clog2(C1+1)-1:0]  chi1;
    logic [$clog2(K1+1)-1:0]  cp1;
    logic [$clog2(OX1+1)-1:0] ox1;
    logic [$clog2(OY1+1)-1:0] oy1;
    logic [K1-1:0]            lm1, rm1, tm1, bm1;

    int vectors = 0;
    int miscompares = 0;
    logic [47:0] exp_q [$];
    int exp_first;

    conv_window_controller #(
        .KER_SIZE(K0), .INPUT_X_DIM(X0), .INPUT_Y_DIM(Y0),
        .PAD(P0), .STRIDE(S0), .CHANNELS(C0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv_a[0]), .in_ready(ir_a[0]),
        .win_ready(wr_a[0]), .win_valid(wv_a[0]), .ch_idx(chi0), .col_ptr(cp0),
        .out_x(ox0), .out_y(oy0), .left_pad_mask(lm0), .right_pad_mask(rm0),
        .top_pad_mask(tm0), .bot_pad_mask(bm0), .frame_done(fd_a[0])
    );

    conv_window_controller #(
        .KER_SIZE(K1), .INPUT_X_DIM(X1), .INPUT_Y_DIM(Y1),
        .PAD(P1), .STRIDE(S1), .CHANNELS(C1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv_a[1]), .in_ready(ir_a[1]),
        .win_ready(wr_a[1]), .win_valid(wv_a[1]), .ch_idx(chi1), .col_ptr(cp1),
        .out_x(ox1), .out_y(oy1), .left_pad_mask(lm1), .right_pad_mask(rm1),
        .top_pad_mask(tm1), .bot_pad_mask(bm1), .frame_done(fd_a[1])
    );

    assign chi_a[0] = 8'(chi0);
    assign cp_a[0]  = 8'(cp0);
    assign ox_a[0]  = 8'(ox0);
    assign oy_a[0]  = 8'(oy0);
    assign lm_a[0]  = 8'(lm0);
    assign rm_a[0]  = 8'(rm0);
    assign tm_a[0]  = 8'(tm0);
    assign bm_a[0]  = 8'(bm0);
    assign chi_a[1] = 8'(chi1);
    assign cp_a[1]  = 8'(cp1);
    assign ox_a[1]  = 8'(ox1);
    assign oy_a[1]  = 8'(oy1);
    assign lm_a[1]  = 8'(lm1);
    assign rm_a[1]  = 8'(rm1);
    assign tm_a[1]  = 8'(tm1);
    assign bm_a[1]  = 8'(bm1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected window list straight from the frame geometry.
    function automatic void build_expected(input int d);
        int k, x, y, p, s, c, px, py;
        k = CK[d]; x = CX[d]; y = CY[d]; p = CP[d]; s = CS[d]; c = CC[d];
        px = x + 2 * p;
        py = y + 2 * p * VP;
        exp_q.delete();
        exp_first = -1;
        for (int r = 0; r < py; r++) begin
            for (int g = 0; g < px; g++) begin
                if (g >= k - 1 && (g - k + 1) % s == 0 && r >= k - 1 && (r - k + 1) % s == 0) begin
                    logic [7:0] l, rt, t, b;
                    l = '0; rt = '0; t = '0; b = '0;
                    for (int i = 0; i < k; i++) begin
                        l[i]  = (g - k + 1 + i) < p;
                        rt[i] = (g - k + 1 + i) >= p + x;
                        t[i]  = (VP != 0) && ((r - k + 1 + i) < p);
                        b[i]  = (VP != 0) && ((r - k + 1 + i) >= p + y);
                    end
                    exp_q.push_back({8'((g - k + 1) / s), 8'((r - k + 1) / s), l, rt, t, b});
                    if (exp_first < 0) exp_first = (r * px + g) * c + c;
                end
            end
        end
    endfunction

    // Raises rst away from a clock edge, checks reset outputs at once, releases after one edge.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({wv_a[d], fd_a[d], ir_a[d], chi_a[d], cp_a[d], ox_a[d], oy_a[d],
                 lm_a[d], rm_a[d], tm_a[d], bm_a[d]} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs d%0d: got wv=%b fd=%b ir=%b ch=%0d cp=%0d x=%0d y=%0d masks=%h/%h/%h/%h expected all zero",
                         d, wv_a[d], fd_a[d], ir_a[d], chi_a[d], cp_a[d], ox_a[d], oy_a[d],
                         lm_a[d], rm_a[d], tm_a[d], bm_a[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs one frame on DUT d; mode 0 continuous, 1 random, 2 five-cycle window stalls.
    task automatic run_frame(input int d, input int mode);
        int n, acc, hold, fd_cnt, first_wv, fd_cyc, total, nbeats, px, py, exp_ch, exp_cp;
        logic [47:0] cur, prev_win;
        logic prev_stall, stall;
        total = exp_q.size();
        nbeats = CX[d] * CY[d] * CC[d];
        px = CX[d] + 2 * CP[d];
        py = CY[d] + 2 * CP[d] * VP;
        n = 0; acc = 0; hold = 0; fd_cnt = 0; first_wv = -1; fd_cyc = -1;
        prev_stall = 1'b0; prev_win = '0;
        for (int cyc = 0; cyc < 4000 && !(n == total && fd_cnt > 0); cyc++) begin
            case (mode)
                0: begin iv_a[d] = 1'b1; wr_a[d] = 1'b1; end
                1: begin iv_a[d] = ($urandom_range(3) != 0); wr_a[d] = ($urandom_range(2) != 0); end
                default: begin iv_a[d] = ($urandom_range(4) != 0); wr_a[d] = (hold >= 5); end
            endcase
            #2;
            cur = {ox_a[d], oy_a[d], lm_a[d], rm_a[d], tm_a[d], bm_a[d]};
            if (prev_stall) begin
                vectors++;
                if (wv_a[d] !== 1'b1 || cur !== prev_win) begin
                    miscompares++;
                    $display("FAIL hold_stable d%0d cyc%0d: got wv=%b win=%h expected wv=1 win=%h", d, cyc, wv_a[d], cur, prev_win);
                end
            end
            stall = (wv_a[d] === 1'b1) && !wr_a[d];
            if (stall) begin
                vectors++;
                if (ir_a[d] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_in_ready d%0d cyc%0d: got %b expected 0", d, cyc, ir_a[d]);
                end
            end
            if (wv_a[d] === 1'b1 && first_wv < 0) first_wv = cyc;
            if (fd_a[d] === 1'b1) begin
                fd_cnt++;
                fd_cyc = cyc;
                vectors++;
                if (wv_a[d] !== 1'b1 || n != total - 1 || acc != nbeats) begin
                    miscompares++;
                    $display("FAIL frame_done d%0d cyc%0d: got wv=%b windows=%0d accepted=%0d expected wv=1 windows=%0d accepted=%0d",
                             d, cyc, wv_a[d], n, acc, total - 1, nbeats);
                end
            end
            if (iv_a[d] && ir_a[d] === 1'b1) begin
                exp_ch = acc % CC[d];
                exp_cp = (CP[d] + ((acc % nbeats) / CC[d]) % CX[d]) % CK[d];
                vectors++;
                if (chi_a[d] !== 8'(exp_ch) || cp_a[d] !== 8'(exp_cp)) begin
                    miscompares++;
                    $display("FAIL beat_index d%0d beat%0d: got ch=%0d col=%0d expected ch=%0d col=%0d",
                             d, acc, chi_a[d], cp_a[d], exp_ch, exp_cp);
                end
                acc++;
            end
            if (wv_a[d] === 1'b1 && wr_a[d]) begin
                vectors++;
                if (n >= total) begin
                    miscompares++;
                    $display("FAIL extra_window d%0d cyc%0d: got window %h expected none", d, cyc, cur);
                end else if (cur !== exp_q[n]) begin
                    miscompares++;
                    $display("FAIL window d%0d #%0d: got %h expected %h", d, n, cur, exp_q[n]);
                end
                n++;
                hold = 0;
            end else if (stall) begin
                hold++;
            end
            prev_stall = stall;
            prev_win = cur;
            @(posedge clk); #1;
        end
        iv_a[d] = 1'b0;
        wr_a[d] = 1'b1;
        vectors++;
        if (n != total || fd_cnt != 1) begin
            miscompares++;
            $display("FAIL frame_end d%0d: got windows=%0d frame_done=%0d expected windows=%0d frame_done=1", d, n, fd_cnt, total);
        end
        if (mode == 0) begin
            vectors++;
            if (first_wv != exp_first || fd_cyc != px * py * CC[d]) begin
                miscompares++;
                $display("FAIL timing d%0d: got first_win=%0d frame_done=%0d expected first_win=%0d frame_done=%0d",
                         d, first_wv, fd_cyc, exp_first, px * py * CC[d]);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < 2; d++) iv_a[d] = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (ir_a[d] !== 1'b0 || wv_a[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL first_pad_col d%0d: got ir=%b wv=%b expected ir=0 wv=0", d, ir_a[d], wv_a[d]);
            end
            iv_a[d] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_continuous();
        apply_reset();
        build_expected(0);
        run_frame(0, 0);
    endtask

    task automatic test_channels_stride();
        apply_reset();
        build_expected(1);
        run_frame(1, 0);
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            apply_reset();
            build_expected(d);
            run_frame(d, 1);
        end
    endtask

    task automatic test_win_stall();
        for (int d = 0; d < 2; d++) begin
            apply_reset();
            build_expected(d);
            run_frame(d, 2);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        build_expected(0);
        run_frame(0, 0);
        run_frame(0, 1);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            iv_a[d] = 1'b1;
            wr_a[d] = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) iv_a[d] = 1'b0;
        apply_reset();
        build_expected(0);
        run_frame(0, 0);
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv_a[d] = 1'b0;
            wr_a[d] = 1'b1;
        end
        @(posedge clk); #1;
        test_reset();
        test_continuous();
        test_channels_stride();
        test_random();
        test_win_stall();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
